sync_debounce: RTL

Multi-channel input conditioner that brings N asynchronous single-bit inputs (buttons, switches, external status lines) into the `clk` domain through a configurable-depth flop chain. Each channel then applies a per-channel stability filter and registered rising/falling edge pulses. It sits at the chip boundary, between raw pins and any consumer logic. It is the generalised successor of the fixed two-flop N-bit synchronizer, adding depth, debounce and edge detection.

---
 rtl/sync_pkg.sv | 15 +
 rtl/sync_debounce_ch.sv | 60 ++++++
 rtl/sync_debounce.sv | 57 +++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared limits and sizing helpers for the pin synchronizer/debouncer family.
// Pure constants and functions; no logic, no latency, no flow control.
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int DB_MIN_CYCLES   = 1;

    // Filter counter width for a given stability requirement, never narrower than one bit.
    function automatic int cnt_width(input int db);
        int w;
        w = $clog2(db + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One channel: flop chain into clk domain, stability filter, registered edge pulses.
// Latency STAGES+DB_CYCLES edges from a held input level; no backpressure, free-running.
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter int   DB_CYCLES = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_d,
    output logic out_q,
    output logic rise_p,
    output logic fall_p,
    output logic commit
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [CW-1:0] cnt;
    logic          s;
    logic          differ;

    assign s      = sync_q[STAGES-1];
    assign differ = s ^ out_q;
    // Level is accepted on the DB_CYCLES-th consecutive differing sample.
    assign commit = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            out_q  <= RESET_VAL;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
        end else begin
            rise_p <= commit & s;
            fall_p <= commit & ~s;
            if (!differ || commit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (commit) begin
                out_q <= s;
            end
        end
    end

endmodule

// File: rtl/sync_debounce.sv
// N independent pin conditioners (sync chain + debounce + edge pulses) with a global change flag.
// Latency STAGES+DB_CYCLES edges per channel; no backpressure, outputs are free-running levels/pulses.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int           N         = 8,
    parameter int           STAGES    = 2,
    parameter int           DB_CYCLES = 4,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_d,
    output logic [N-1:0] out_q,
    output logic [N-1:0] rise_p,
    output logic [N-1:0] fall_p,
    output logic         any_change
);

    if (N < 1) begin : g_bad_n
        $error("sync_debounce: N must be at least 1");
    end
    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_debounce: STAGES below minimum synchronizer depth");
    end
    if (DB_CYCLES < DB_MIN_CYCLES) begin : g_bad_db
        $error("sync_debounce: DB_CYCLES below minimum");
    end

    logic [N-1:0] commit;

    for (genvar i = 0; i < N; i++) begin : g_ch
        sync_debounce_ch #(
            .STAGES    (STAGES),
            .DB_CYCLES (DB_CYCLES),
            .RESET_VAL (RESET_VAL[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .in_d   (in_d[i]),
            .out_q  (out_q[i]),
            .rise_p (rise_p[i]),
            .fall_p (fall_p[i]),
            .commit (commit[i])
        );
    end

    // Registered from the same next-state as the pulses so it lines up with them.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |commit;
        end
    end

endmodule
